pong_ball_ctrl: RTL
===================

// Module: pong_ball_ctrl
// PURPOSE
//   Ball engine: produces the ball position consumed by the game FSM's scoring logic.
//   Advances the ball one pixel per axis every SPEED clocks while the game runs.
//   Reflects the ball off side walls and off both paddles.
//   On a miss, parks the ball on the top edge row (y=1) or bottom edge row (y=HEIGHT-1)
//   for one step period, so the FSM's scoring logic can award exactly one point; then re-serves.
// PARAMETERS
//   SPEED        500000  clocks per ball step (>=2)
//   WIDTH        240     screen width, x range 0..WIDTH-1
//   HEIGHT       320     screen height, y range 1..HEIGHT-1
//   PADDLE_W     40      paddle width in pixels
//   PADDLE_Y     16      paddle row distance from edge: top paddle y=PADDLE_Y, bottom y=HEIGHT-1-PADDLE_Y
//   SERVE_STEPS  60      step periods the ball holds at centre before moving
// PORTS
//   clock      in   1  system clock
//   reset      in   1  asynchronous reset, active-high
//   running    in   1  game-active flag from the game FSM
//   paddle0X   in   8  left x of top paddle (player 0)
//   paddle1X   in   8  left x of bottom paddle (player 1)
//   ballX      out  8  ball x
//   ballY      out  9  ball y
//   hit        out  1  one-clock pulse on any paddle reflection
//   serving    out  1  high in IDLE and SERVE
// BEHAVIOUR
//   Reset:
//     state=IDLE, ballX=WIDTH/2 (120), ballY=HEIGHT/2 (160), dirX=+1, dirY=+1 (down).
//     hit=0, serving=1, stepCnt=0, serveCnt=0.
//   Step tick: stepCnt counts 0..SPEED-1 and wraps; a tick is the cycle with stepCnt==SPEED-1.
//     stepCnt clears on every state entry.
//     Position registers update on the tick edge; no other latency.
//   FSM:
//   - IDLE: ball held at centre. running=1 -> SERVE.
//   - SERVE: ball held at centre. serveCnt increments per tick.
//     At the SERVE_STEPS-th tick -> MOVE, and the first step happens one full period later.
//   - MOVE: on each tick, compute X and Y independently.
//     Both axis rules may fire on the same tick (corner case): apply both.
//   - DWELL: hold position for one full period (SPEED clocks).
//     Then ballX/ballY return to centre, dirX is kept, and the state goes to SERVE.
//     dirY points toward the conceding edge: -1 if the miss was at y=1, +1 if at HEIGHT-1.
//   - running=0 in any state -> IDLE next edge: ball centred, counters cleared, hit=0.
//   X rule:
//     dirX=+1 at x=WIDTH-1 -> x=WIDTH-2, dirX=-1.
//     dirX=-1 at x=0 -> x=1, dirX=+1.
//     Otherwise x+=dirX.
//   Y rule:
//   - Top-paddle hit: dirY=-1, y==PADDLE_Y+1, and paddle0X<=x<=paddle0X+PADDLE_W-1.
//     Result: y=y+1, dirY=+1, hit=1 for one clock.
//   - Bottom-paddle hit: dirY=+1, y==HEIGHT-2-PADDLE_Y, same x test with paddle1X.
//     Result: y=y-1, dirY=-1, hit=1 for one clock.
//   - Paddle x test uses the pre-step x.
//     Compare at 9 bits so paddleX+PADDLE_W never wraps; paddle may extend past WIDTH-1.
//   - Otherwise y+=dirY. If the new y is 1 or HEIGHT-1 -> DWELL.
//   - ballY never leaves 1..HEIGHT-1; ballX never leaves 0..WIDTH-1.
//   Paddle inputs are sampled only on ticks, and may change at any time.
//   Reset asserted mid-operation (any state, including DWELL): immediate reset values.
//     No point-dwell is resumed after reset.
// TESTING  (SPEED=4, SERVE_STEPS=2, WIDTH=240, HEIGHT=320, PADDLE_W=40, PADDLE_Y=16)
//   1. Reset, running=0 for 100 clocks -> ballX=120, ballY=160, hit=0, serving=1 throughout.
//   2. running=1 -> centre held 8 clocks (2 ticks); (121,161) after 4 more clocks; serving=0.
//   3. paddle1X=200, run -> x reaches 239 at step 119, then 238 with dirX=-1.
//      At step 142, (216,302) bounces to (215,301): hit pulses 1 clock, dirY=-1.
//   4. paddle1X=0, paddle0X=0 -> ball reaches y=319 and holds 4 clocks.
//      Then (120,160), dirY=+1, SERVE.
//   5. Mid-MOVE, running 1->0 -> next edge (120,160), serving=1, state IDLE.
//      running=1 again -> full SERVE_STEPS delay before moving.
//   6. Assert reset during DWELL at y=1 -> outputs go to reset values asynchronously.
//      After release with running=1, a normal serve follows.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// Ball engine for the pong game: steps the ball once per SPEED clocks, bounces it off
// walls and paddles, parks it on the edge row for one period after a miss, then re-serves.
module pong_ball_ctrl #(
   parameter int SPEED       = 500000,
   parameter int WIDTH       = 240,
   parameter int HEIGHT      = 320,
   parameter int PADDLE_W    = 40,
   parameter int PADDLE_Y    = 16,
   parameter int SERVE_STEPS = 60
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       running_i,
   input  logic [7:0] paddle0_x_i,
   input  logic [7:0] paddle1_x_i,
   output logic [7:0] ball_x_o,
   output logic [8:0] ball_y_o,
   output logic       hit_o,
   output logic       serving_o
);

   localparam int CNT_W = (SPEED > 1) ? $clog2(SPEED) : 1;
   localparam int SRV_W = $clog2(SERVE_STEPS + 1);

   localparam logic [7:0]       X_CTR      = 8'(WIDTH / 2);
   localparam logic [7:0]       X_MAX      = 8'(WIDTH - 1);
   localparam logic [7:0]       X_MAX_M1   = 8'(WIDTH - 2);
   localparam logic [8:0]       Y_CTR      = 9'(HEIGHT / 2);
   localparam logic [8:0]       Y_TOP      = 9'd1;
   localparam logic [8:0]       Y_BOT      = 9'(HEIGHT - 1);
   localparam logic [8:0]       Y_TOP_PAD  = 9'(PADDLE_Y + 1);
   localparam logic [8:0]       Y_BOT_PAD  = 9'(HEIGHT - 2 - PADDLE_Y);
   localparam logic [8:0]       PAD_SPAN   = 9'(PADDLE_W - 1);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(SPEED - 1);
   localparam logic [SRV_W-1:0] SERVE_LAST = SRV_W'(SERVE_STEPS - 1);

   typedef enum logic [1:0] {IDLE, SERVE, MOVE, DWELL} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] step_cnt_q;
   logic [SRV_W-1:0] serve_cnt_q;
   logic [7:0]       ball_x_q;
   logic [8:0]       ball_y_q;
   logic             dir_x_q;   // 1 = +1 (right)
   logic             dir_y_q;   // 1 = +1 (down)
   logic             hit_q;
   logic             serving_q;

   logic       tick;
   logic [8:0] x9;
   logic       top_in;
   logic       bot_in;
   logic [7:0] x_d;
   logic       dir_x_d;
   logic [8:0] y_d;
   logic       dir_y_d;
   logic       hit_d;
   logic       miss_d;

   // Paddle span is compared at 9 bits so a paddle hanging past the right wall never wraps.
   always_comb begin
      tick   = (step_cnt_q == STEP_LAST);
      x9     = {1'b0, ball_x_q};
      top_in = (x9 >= {1'b0, paddle0_x_i}) && (x9 <= ({1'b0, paddle0_x_i} + PAD_SPAN));
      bot_in = (x9 >= {1'b0, paddle1_x_i}) && (x9 <= ({1'b0, paddle1_x_i} + PAD_SPAN));

      if (dir_x_q && (ball_x_q == X_MAX)) begin
         x_d     = X_MAX_M1;
         dir_x_d = 1'b0;
      end else if (!dir_x_q && (ball_x_q == 8'd0)) begin
         x_d     = 8'd1;
         dir_x_d = 1'b1;
      end else begin
         x_d     = dir_x_q ? (ball_x_q + 8'd1) : (ball_x_q - 8'd1);
         dir_x_d = dir_x_q;
      end

      hit_d   = 1'b0;
      miss_d  = 1'b0;
      dir_y_d = dir_y_q;
      if (!dir_y_q && (ball_y_q == Y_TOP_PAD) && top_in) begin
         y_d     = ball_y_q + 9'd1;
         dir_y_d = 1'b1;
         hit_d   = 1'b1;
      end else if (dir_y_q && (ball_y_q == Y_BOT_PAD) && bot_in) begin
         y_d     = ball_y_q - 9'd1;
         dir_y_d = 1'b0;
         hit_d   = 1'b1;
      end else begin
         y_d    = dir_y_q ? (ball_y_q + 9'd1) : (ball_y_q - 9'd1);
         miss_d = (y_d == Y_TOP) || (y_d == Y_BOT);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         step_cnt_q  <= '0;
         serve_cnt_q <= '0;
         ball_x_q    <= X_CTR;
         ball_y_q    <= Y_CTR;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         hit_q       <= 1'b0;
         serving_q   <= 1'b1;
      end else begin
         hit_q      <= 1'b0;
         step_cnt_q <= tick ? '0 : (step_cnt_q + CNT_W'(1));
         if (!running_i) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            serve_cnt_q <= '0;
            ball_x_q    <= X_CTR;
            ball_y_q    <= Y_CTR;
            serving_q   <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q     <= SERVE;
                  step_cnt_q  <= '0;
                  serve_cnt_q <= '0;
               end
               SERVE: begin
                  if (tick) begin
                     if (serve_cnt_q == SERVE_LAST) begin
                        state_q     <= MOVE;
                        serve_cnt_q <= '0;
                        serving_q   <= 1'b0;
                     end else begin
                        serve_cnt_q <= serve_cnt_q + SRV_W'(1);
                     end
                  end
               end
               MOVE: begin
                  if (tick) begin
                     ball_x_q <= x_d;
                     dir_x_q  <= dir_x_d;
                     ball_y_q <= y_d;
                     dir_y_q  <= dir_y_d;
                     hit_q    <= hit_d;
                     if (miss_d) state_q <= DWELL;
                  end
               end
               DWELL: begin
                  // Re-serve toward the edge that conceded.
                  if (tick) begin
                     state_q   <= SERVE;
                     ball_x_q  <= X_CTR;
                     ball_y_q  <= Y_CTR;
                     dir_y_q   <= (ball_y_q != Y_TOP);
                     serving_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ball_x_o  = ball_x_q;
   assign ball_y_o  = ball_y_q;
   assign hit_o     = hit_q;
   assign serving_o = serving_q;

endmodule
